// File: rtl/rotor_stepper.sv
`default_nettype none
// ============================================================================
// Module   : rotor_stepper
// Brief    : Rotor position engine; advances NUM_ROTORS positions once per
//            accepted keypress using per-rotor notches. Optional macro
//            ROTOR_DOUBLE_STEP_EN selects Enigma double stepping instead of
//            a plain base-ALPHA odometer carry.
// Revision : 1.0 - initial release
// ============================================================================
module rotor_stepper #(
  parameter int NUM_ROTORS = 3,
  parameter int ALPHA      = 26,
  parameter int POS_W      = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [NUM_ROTORS*POS_W-1:0] start_pos,
  input  logic [NUM_ROTORS*POS_W-1:0] notch_pos,
  input  logic                        key_valid,
  output logic                        key_ready,
  output logic                        step_done,
  output logic [NUM_ROTORS*POS_W-1:0] pos_out,
  output logic                        cfg_err
);

  localparam int                c_w     = NUM_ROTORS * POS_W;
  localparam logic [POS_W:0]    c_alpha = (POS_W+1)'(ALPHA);
  localparam logic [POS_W-1:0]  c_last  = POS_W'(ALPHA - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_STEP = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [c_w-1:0]          r_pos;
  logic [c_w-1:0]          r_notch;
  logic                    r_cfg_err;
  logic                    r_step_done;

  logic [NUM_ROTORS-1:0]   w_at;
  logic [NUM_ROTORS-1:0]   w_step;
  logic [NUM_ROTORS-1:0]   w_bad;
  logic [c_w-1:0]          w_pos_stepped;
  logic [c_w-1:0]          w_pos_load;
  logic                    w_cfg_err;
  logic                    w_unused;

  generate
    for (genvar i = 0; i < NUM_ROTORS; i++) begin : g_rotor
      logic [POS_W-1:0] w_p;
      logic [POS_W-1:0] w_n;
      logic [POS_W-1:0] w_s;
      logic             w_start_bad;
      logic             w_notch_bad;

      assign w_p     = r_pos[i*POS_W +: POS_W];
      assign w_n     = r_notch[i*POS_W +: POS_W];
      assign w_s     = start_pos[i*POS_W +: POS_W];
      assign w_at[i] = (w_p == w_n);

      if (i == 0) begin : g_fast
        assign w_step[i] = 1'b1;
      end else begin : g_carry
`ifdef ROTOR_DOUBLE_STEP_EN
        // A middle rotor sitting on its own notch drags itself along with
        // its left neighbour; the slowest rotor has no pawl to do that.
        if (i <= NUM_ROTORS - 2) begin : g_middle
          assign w_step[i] = w_at[i-1] | w_at[i];
        end else begin : g_slow
          assign w_step[i] = w_at[i-1];
        end
`else
        assign w_step[i] = w_step[i-1] & w_at[i-1];
`endif
      end

      assign w_pos_stepped[i*POS_W +: POS_W] =
        !w_step[i]       ? w_p :
        (w_p == c_last)  ? '0  : w_p + 1'b1;

      assign w_start_bad = ({1'b0, w_s} >= c_alpha);
      assign w_notch_bad = ({1'b0, notch_pos[i*POS_W +: POS_W]} >= c_alpha);
      assign w_pos_load[i*POS_W +: POS_W] = w_start_bad ? '0 : w_s;
      assign w_bad[i] = w_start_bad | w_notch_bad;
    end
  endgenerate

  assign w_cfg_err = |w_bad;
  // The slowest rotor's notch never influences any step decision.
  assign w_unused  = w_at[NUM_ROTORS-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (load) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (key_valid) w_state_nxt = ST_STEP;
        ST_STEP: w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos       <= '0;
      r_notch     <= '0;
      r_cfg_err   <= 1'b0;
      r_step_done <= 1'b0;
    end else if (load) begin
      r_pos       <= w_pos_load;
      r_notch     <= notch_pos;
      r_cfg_err   <= w_cfg_err;
      r_step_done <= 1'b0;
    end else begin
      r_step_done <= (r_state == ST_STEP);
      if (r_state == ST_STEP) begin
        r_pos <= w_pos_stepped;
      end
    end
  end

  assign key_ready = (r_state == ST_IDLE);
  assign step_done = r_step_done;
  assign pos_out   = r_pos;
  assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_rotor_stepper.sv
`default_nettype none
// ============================================================================
// Module   : tb_rotor_stepper
// Brief    : Self-checking bench for rotor_stepper; expected positions are
//            queued on each keypress and popped when step_done pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rotor_stepper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [14:0] start_pos = '0;
  logic [14:0] notch_pos = '0;
  logic        key_valid = 1'b0;
  logic        key_ready;
  logic        step_done;
  logic [14:0] pos_out;
  logic        cfg_err;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_done = 0;
  logic [14:0] exp_q[$];

  rotor_stepper #(.NUM_ROTORS(3), .ALPHA(26), .POS_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .start_pos (start_pos),
    .notch_pos (notch_pos),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .step_done (step_done),
    .pos_out   (pos_out),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] p3(input int a2, input int a1, input int a0);
    return {a2[4:0], a1[4:0], a0[4:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (step_done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_step_done", 32'(step_done), 32'd0);
      end else begin
        check("pos_at_step_done", 32'(pos_out), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [14:0] s, input logic [14:0] n);
    start_pos = s;
    notch_pos = n;
    load      = 1'b1;
    tick();
    load      = 1'b0;
  endtask

  task automatic press(input logic [14:0] exp);
    exp_q.push_back(exp);
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int d0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_pos", 32'(pos_out), 32'd0);
    check("rst_key_ready", 32'(key_ready), 32'd1);
    check("rst_step_done", 32'(step_done), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);

    // ADU -> ADV -> AEW -> (BFX or AEX)
    do_load(p3(0, 3, 20), p3(16, 4, 21));
    check("load_pos", 32'(pos_out), 32'(p3(0, 3, 20)));
    check("load_cfg_err", 32'(cfg_err), 32'd0);
    press(p3(0, 3, 21));
    press(p3(0, 4, 22));
`ifdef ROTOR_DOUBLE_STEP_EN
    press(p3(1, 5, 23));
`else
    press(p3(0, 4, 23));
`endif

    // Full wrap of every rotor
    do_load(p3(25, 25, 25), p3(25, 25, 25));
    d0 = n_done;
    press(p3(0, 0, 0));
    check("wrap_done_count", 32'(n_done - d0), 32'd1);

    // Held key_valid: one acceptance every other cycle
    do_load(p3(0, 0, 0), p3(10, 10, 10));
    exp_q.push_back(p3(0, 0, 1));
    exp_q.push_back(p3(0, 0, 2));
    exp_q.push_back(p3(0, 0, 3));
    d0 = n_done;
    key_valid = 1'b1;
    for (int j = 0; j < 6; j++) begin
      check($sformatf("hs_key_ready_%0d", j), 32'(key_ready), ((j % 2) == 0) ? 32'd1 : 32'd0);
      tick();
    end
    key_valid = 1'b0;
    tick();
    tick();
    check("hs_done_count", 32'(n_done - d0), 32'd3);
    check("hs_pos", 32'(pos_out), 32'(p3(0, 0, 3)));

    // Load during STEP aborts the step
    do_load(p3(1, 1, 1), p3(10, 10, 10));
    d0 = n_done;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    check("abort_in_step", 32'(key_ready), 32'd0);
    do_load(p3(7, 7, 7), p3(10, 10, 10));
    check("abort_pos", 32'(pos_out), 32'(p3(7, 7, 7)));
    check("abort_key_ready", 32'(key_ready), 32'd1);
    check("abort_step_done", 32'(step_done), 32'd0);
    tick();
    tick();
    check("abort_done_count", 32'(n_done - d0), 32'd0);

    // Reset during STEP
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_pos", 32'(pos_out), 32'd0);
    check("rst_mid_key_ready", 32'(key_ready), 32'd1);
    check("rst_mid_step_done", 32'(step_done), 32'd0);
    tick();
    check("rst_mid_done_count", 32'(n_done - d0), 32'd0);

    // Out-of-range configuration
    do_load(p3(2, 2, 30), p3(10, 10, 10));
    check("cfg_bad_start_pos", 32'(pos_out), 32'(p3(2, 2, 0)));
    check("cfg_bad_start_err", 32'(cfg_err), 32'd1);
    do_load(p3(1, 2, 3), p3(10, 10, 10));
    check("cfg_good_err", 32'(cfg_err), 32'd0);
    check("cfg_good_pos", 32'(pos_out), 32'(p3(1, 2, 3)));
    do_load(p3(4, 5, 6), p3(27, 10, 10));
    check("cfg_bad_notch_err", 32'(cfg_err), 32'd1);
    check("cfg_bad_notch_pos", 32'(pos_out), 32'(p3(4, 5, 6)));

    // Load and key in the same cycle: load wins
    d0 = n_done;
    key_valid = 1'b1;
    do_load(p3(4, 4, 4), p3(10, 10, 10));
    key_valid = 1'b0;
    check("ldkey_key_ready", 32'(key_ready), 32'd1);
    check("ldkey_pos", 32'(pos_out), 32'(p3(4, 4, 4)));
    check("ldkey_cfg_err", 32'(cfg_err), 32'd0);
    tick();
    tick();
    check("ldkey_done_count", 32'(n_done - d0), 32'd0);
    check("ldkey_pos_hold", 32'(pos_out), 32'(p3(4, 4, 4)));

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rotor_stepper.md
Name: rotor_stepper

Overview:
- Clocked, parametrised rotor position engine for the Enigma datapath.
- Holds NUM_ROTORS rotor positions in 0..ALPHA-1 and advances them once per accepted keypress.
- Uses per-rotor notch positions, including the mechanical double-step anomaly.
- Sits between keypad/UART front end and the rotor substitution chain; downstream logic samples pos_out when step_done pulses.

Parameters:
- NUM_ROTORS, 3, number of rotors; index 0 is fastest (rightmost), index NUM_ROTORS-1 slowest; legal range 1..8.
- ALPHA, 26, alphabet size; positions wrap ALPHA-1 -> 0.
- POS_W, 5, bits per position; ALPHA <= 2**POS_W required.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous, active-high reset.
- load, input, 1, one-cycle pulse; loads start_pos and notch_pos.
- start_pos, input, NUM_ROTORS*POS_W, start positions; rotor i at bits [i*POS_W +: POS_W].
- notch_pos, input, NUM_ROTORS*POS_W, notch positions, same packing; latched on load.
- key_valid, input, 1, keypress request.
- key_ready, output, 1, engine can accept a keypress.
- step_done, output, 1, one-cycle pulse: pos_out holds post-step positions.
- pos_out, output, NUM_ROTORS*POS_W, current positions, same packing.
- cfg_err, output, 1, last load contained an out-of-range value.

Behaviour:
- Reset (rst=1 at clock edge, highest priority, any state):
  - pos_out=0, internal notch registers=0, state=IDLE.
  - key_ready=1, step_done=0, cfg_err=0.
- States: IDLE, STEP. key_ready=1 only in IDLE.
- IDLE:
  - key_valid & key_ready at edge k -> state=STEP; pre-step positions are used for all decisions.
  - At edge k+1: positions update, state=IDLE, step_done=1 for exactly the cycle after edge k+1.
  - Throughput: 1 key per 2 cycles. key_valid held high gives a step every other cycle.
- Step rule, evaluated on pre-step positions p[i] and notches n[i]; at[i] = (p[i]==n[i]):
  - rotor 0 always steps.
  - ROTOR_DOUBLE_STEP_EN defined: rotor i (i>=1) steps if at[i-1], OR (1<=i<=NUM_ROTORS-2 AND at[i]). The slowest rotor never self-steps.
  - ROTOR_DOUBLE_STEP_EN undefined: rotor i (i>=1) steps if rotor i-1 steps AND at[i-1] (pure odometer carry).
  - A stepping rotor goes p -> p+1, or ALPHA-1 -> 0. No position ever leaves 0..ALPHA-1.
- load (priority over key acceptance and over a pending STEP):
  - Latches notch_pos. Loads each start_pos field; any field >= ALPHA loads as 0.
  - cfg_err=1 if any start or notch field >= ALPHA, else 0. cfg_err holds until next load or rst.
  - state=IDLE, no step_done.
  - load in STEP aborts the step: the loaded values win, no step_done.
  - load and key_valid in the same IDLE cycle: load wins, key not accepted (key_ready is still 1 that cycle, so the source must retry).
- NUM_ROTORS=1: rotor 0 only; notch has no effect.
- NUM_ROTORS=2 with ROTOR_DOUBLE_STEP_EN: no middle rotor exists, so no double step.
- Outputs are registered; no combinational path from key_valid to pos_out.

Optional Feature:
- Macro ROTOR_DOUBLE_STEP_EN.
- Defined: Enigma-accurate double stepping as given above.
- Undefined: odometer carry only, giving a clean base-ALPHA counter for test and debug builds.
- Ports and timing are identical in both builds.

Test Plan:
- Defaults, EN defined. Load start {r2,r1,r0}={0,3,20}, notch {16,4,21}; three keys -> after each step_done pos {0,3,21}, {0,4,22}, {1,5,23} (ADU->ADV->AEW->BFX double step).
- Same load, EN undefined: three keys -> {0,3,21}, {0,4,22}, {0,4,23}.
- Wrap: load {25,25,25}, notch {25,25,25}, EN undefined, one key -> {0,0,0}, step_done once.
- Handshake: key_valid held high 6 cycles from IDLE -> key_ready toggles 1,0,1,0,1,0; exactly 3 step_done pulses; r0 advances 3.
- Abort/priority: key accepted, then load {7,7,7} during STEP -> pos {7,7,7}, no step_done. Separately, rst mid-STEP -> pos {0,0,0}, key_ready=1.
- Config error: load start r0=30 -> r0=0, cfg_err=1; next valid load -> cfg_err=0.
